div_unsigned_seq: RTL and testbench

Sequential unsigned divider, the inverse of the team's combinational unsigned array multiplier (mul_unsigned family). Accepts a WIDTH-bit dividend and divisor on a start pulse, runs a restoring shift-subtract loop one quotient bit per clock, and presents quotient and remainder with a one-cycle done strobe. Intended for multiply/divide round-trip checks in the arithmetic labs and for any datapath that can tolerate multi-cycle division latency.

---
 rtl/div_unsigned_seq.sv | 117 +++++++++++
 tb/tb_div_unsigned_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unsigned_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional DIV_UNSIGNED_ZERO_CHK_EN: b=0 bypasses the loop and raises dz.
module div_unsigned_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             last;

  // a_q doubles as the quotient register: dividend bits shift
  // out of the top while quotient bits shift in at the bottom.
  always_comb begin
    rem_sh = {rem_q, a_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};
    ge     = ~diff[WIDTH];
    rem_d  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_d  = {a_q[WIDTH-2:0], ge};
    last   = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef DIV_UNSIGNED_ZERO_CHK_EN
  logic dz_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
`ifdef DIV_UNSIGNED_ZERO_CHK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
`ifdef DIV_UNSIGNED_ZERO_CHK_EN
            if (b == '0) begin
              state_q <= DONE;
              q_q     <= '1;
              r_q     <= a;
              dz_q    <= 1'b1;
            end
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          a_q   <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q <= DONE;
            q_q     <= quo_d;
            r_q     <= rem_d;
`ifdef DIV_UNSIGNED_ZERO_CHK_EN
            dz_q    <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign q    = q_q;
  assign r    = r_q;
`ifdef DIV_UNSIGNED_ZERO_CHK_EN
  assign dz   = dz_q;
`else
  assign dz   = 1'b0;
`endif

endmodule

// File: tb/tb_div_unsigned_seq.sv
// Bench for div_unsigned_seq: vector table, corner sequences,
// exhaustive sweep, scoreboard of expected results and due cycles.
module tb_div_unsigned_seq;

`ifdef DIV_UNSIGNED_ZERO_CHK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] q;
  logic [3:0] r;
  logic       dz;

  div_unsigned_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Called at a negedge; leaves the bench at a later negedge.
  task automatic issue(input logic [3:0] va, input logic [3:0] vb,
                       input logic [3:0] eq, input logic [3:0] er,
                       input bit hold);
    int   n = 0;
    exp_t e;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) flag("issue_timeout");
    a     = va;
    b     = vb;
    start = 1'b1;
    e.a   = va;
    e.b   = vb;
    e.q   = eq;
    e.r   = er;
    e.dz  = ZCHK && (vb == 4'd0);
    e.due = cyc + ((ZCHK && vb == 4'd0) ? 1 : 5);
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) flag("drain_timeout");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        chk("busy_at_done", int'(busy), 0);
        if (sb.size() == 0) begin
          flag("unexpected_done");
        end else begin
          e = sb.pop_front();
          chk("q", int'(q), int'(e.q));
          chk("r", int'(r), int'(e.r));
          chk("dz", int'(dz), int'(e.dz));
          chk("done_cycle", cyc, e.due);
          if (e.b != 4'd0) begin
            chk("q*b+r", int'(q) * int'(e.b) + int'(r), int'(e.a));
            chk("r<b", int'(r < e.b), 1);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        flag("missing_done");
        void'(sb.pop_front());
      end
    end
  end

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{4'd13, 4'd3,  4'd4,  4'd1};
    tbl[1]  = '{4'd15, 4'd1,  4'd15, 4'd0};
    tbl[2]  = '{4'd0,  4'd7,  4'd0,  4'd0};
    tbl[3]  = '{4'd9,  4'd2,  4'd4,  4'd1};
    tbl[4]  = '{4'd14, 4'd4,  4'd3,  4'd2};
    tbl[5]  = '{4'd5,  4'd0,  4'd15, 4'd5};
    tbl[6]  = '{4'd7,  4'd7,  4'd1,  4'd0};
    tbl[7]  = '{4'd15, 4'd15, 4'd1,  4'd0};
    tbl[8]  = '{4'd1,  4'd15, 4'd0,  4'd1};
    tbl[9]  = '{4'd15, 4'd2,  4'd7,  4'd1};
    tbl[10] = '{4'd8,  4'd3,  4'd2,  4'd2};
    tbl[11] = '{4'd12, 4'd5,  4'd2,  4'd2};
    tbl[12] = '{4'd11, 4'd4,  4'd2,  4'd3};
    tbl[13] = '{4'd6,  4'd0,  4'd15, 4'd6};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_dz", int'(dz), 0);
    rst = 1'b0;
    @(negedge clk);

    // single op, then results must hold
    issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    chk("hold_q", int'(q), 4);
    chk("hold_r", int'(r), 1);
    chk("hold_done", int'(done), 0);

    // back-to-back with start held high
    issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b1);
    issue(4'd0, 4'd7, 4'd0, 4'd0, 1'b0);
    drain();

    // divide by zero
    issue(4'd5, 4'd0, 4'd15, 4'd5, 1'b0);
    drain();

    // start during busy is ignored
    issue(4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
    start = 1'b1;
    a     = 4'd1;
    b     = 4'd1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset in the 2nd CALC cycle aborts the op
    issue(4'd14, 4'd4, 4'd3, 4'd2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(q), 0);
    chk("abort_r", int'(r), 0);
    chk("abort_dz", int'(dz), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(4'd14, 4'd4, 4'd3, 4'd2, 1'b0);
    drain();

    for (int i = 0; i < 14; i++)
      issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, 1'b0);
    drain();

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++)
        issue(4'(ia), 4'(ib), 4'(ia / ib), 4'(ia % ib), 1'b0);
    end
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
